multi_port_register_file: RTL

//  Parametrised successor to the single-write, two-read RegisterFile. Provides DEPTH x WIDTH general-purpose storage.
//  Has NUM_READ combinational read ports and two write ports, with optional write-to-read bypass and hardwired-zero entry 0.

---
 rtl/multi_port_register_file_pkg.sv | 21 ++
 rtl/multi_port_register_file_rf_read_port.sv | 53 +++++
 rtl/multi_port_register_file.sv | 79 +++++++
 3 files changed

// File: rtl/multi_port_register_file_pkg.sv
// +----------------------------------------------------------------------------+
// | multi_port_register_file_pkg                                               |
// | Shared defaults and helpers for the multi-port register file.              |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package multi_port_register_file_pkg;

    localparam int c_rf_width_default = 64;
    localparam int c_rf_depth_default = 32;
    localparam int c_rf_zero_addr     = 0;

    // Address width for a power-of-two depth; floor of 1 keeps buses legal.
    function automatic int rf_addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multi_port_register_file_rf_read_port.sv
// +----------------------------------------------------------------------------+
// | rf_read_port                                                               |
// | One combinational read port: array mux, write bypass and zero rule.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module rf_read_port
    import multi_port_register_file_pkg::*;
#(
    parameter int WIDTH    = c_rf_width_default,
    parameter int DEPTH    = c_rf_depth_default,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = rf_addr_w(DEPTH)
) (
    input  logic              rst,
    input  logic [WIDTH-1:0]  regs [DEPTH],
    input  logic [ADDR_W-1:0] read_addr,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [WIDTH-1:0]  wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [WIDTH-1:0]  wdata1,
    output logic [WIDTH-1:0]  read_data
);

    localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(c_rf_zero_addr);

    logic w_hit0;
    logic w_hit1;

    assign w_hit0 = (BYPASS != 0) && !rst && we0 && (waddr0 == read_addr);
    assign w_hit1 = (BYPASS != 0) && !rst && we1 && (waddr1 == read_addr);

    // Later assignments take priority: zero rule over port 1 over port 0.
    always_comb begin
        read_data = regs[read_addr];
        if (w_hit0) begin
            read_data = wdata0;
        end
        if (w_hit1) begin
            read_data = wdata1;
        end
        if ((ZERO_REG != 0) && (read_addr == c_zero_addr)) begin
            read_data = '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/multi_port_register_file.sv
// +----------------------------------------------------------------------------+
// | multi_port_register_file                                                   |
// | DEPTH x WIDTH register file, two write ports, NUM_READ read ports.         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module multi_port_register_file
    import multi_port_register_file_pkg::*;
#(
    parameter int WIDTH    = c_rf_width_default,
    parameter int DEPTH    = c_rf_depth_default,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = rf_addr_w(DEPTH)
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         RegWrite0,
    input  logic [ADDR_W-1:0]            WriteReg0,
    input  logic [WIDTH-1:0]             WriteData0,
    input  logic                         RegWrite1,
    input  logic [ADDR_W-1:0]            WriteReg1,
    input  logic [WIDTH-1:0]             WriteData1,
    input  logic [NUM_READ*ADDR_W-1:0]   ReadReg,
    output logic [NUM_READ*WIDTH-1:0]    ReadData
);

    localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(c_rf_zero_addr);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic             w_we0;
    logic             w_we1;

    assign w_we0 = RegWrite0 && !((ZERO_REG != 0) && (WriteReg0 == c_zero_addr));
    assign w_we1 = RegWrite1 && !((ZERO_REG != 0) && (WriteReg1 == c_zero_addr));

    // Port 1 is applied last so the younger retire slot wins an address clash.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_we0) begin
                r_regs[WriteReg0] <= WriteData0;
            end
            if (w_we1) begin
                r_regs[WriteReg1] <= WriteData1;
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_READ; k++) begin : g_read_port
            rf_read_port #(
                .WIDTH    (WIDTH),
                .DEPTH    (DEPTH),
                .BYPASS   (BYPASS),
                .ZERO_REG (ZERO_REG)
            ) u_read_port (
                .rst       (Reset),
                .regs      (r_regs),
                .read_addr (ReadReg[k*ADDR_W +: ADDR_W]),
                .we0       (RegWrite0),
                .waddr0    (WriteReg0),
                .wdata0    (WriteData0),
                .we1       (RegWrite1),
                .waddr1    (WriteReg1),
                .wdata1    (WriteData1),
                .read_data (ReadData[k*WIDTH +: WIDTH])
            );
        end
    endgenerate

endmodule

`default_nettype wire
